// File: rtl/conv_ctrl_pkg.sv
// Shared state type, default geometry and coordinate width for the conv frame sequencer.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package conv_ctrl_pkg;

    localparam int COORD_W      = 11;
    localparam int DEF_IMG_W    = 1280;
    localparam int DEF_IMG_H    = 960;
    localparam int DEF_BORDER   = 10;
    localparam int DEF_PIPE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACTIVE,
        DONE
    } ctrlState_t;

endpackage

// File: rtl/conv_valid_dly.sv
// DEPTH-stage 1-bit delay line that carries the window-valid flag alongside the filter datapath.
// Latency: DEPTH cycles from iD to oQ.
// Backpressure: none; it shifts every cycle, and reset flushes every stage at once.
module conv_valid_dly #(
    parameter int DEPTH = 2
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iD,
    output logic oQ
);

    logic [DEPTH-1:0] shiftQ;

    // Advance the flag one stage per clock; reset empties the whole line.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            shiftQ <= '0;
        end else begin
            shiftQ[0] <= iD;
            for (int i = 1; i < DEPTH; i++) begin
                shiftQ[i] <= shiftQ[i-1];
            end
        end
    end

    assign oQ = shiftQ[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: pixel coordinates, line-buffer enable, border mask and per-frame direction latch.
// Latency: coordinates 1 cycle after acceptance; oWIN_VALID 1+PIPE_LAT cycles; oLB_EN combinational.
// Backpressure: none, the sensor stream cannot be stalled. CONV_CTRL_STATS_EN adds the oFRAME_CNT counter.
module conv_frame_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int BORDER   = DEF_BORDER,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic               iSW,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont,
    output logic               oLB_EN,
    output logic               oIsHorz,
    output logic               oWIN_VALID,
    output logic               oBUSY,
    output logic               oFRAME_DONE,
    output logic               oFRAME_ERR
`ifdef CONV_CTRL_STATS_EN
    ,
    output logic [15:0]        oFRAME_CNT
`endif
);

    ctrlState_t         state, nextState;
    logic               fvalPrev, fvalArmed, fvalRise, fvalFall;
    logic               running, accept, startFrame, shortEnd;
    logic               pixSeen, ovf, inBorder, inBorderQ;
    logic [COORD_W-1:0] pixX, pixY;

    // A rising edge only counts after iFVAL has been seen low since reset,
    // so a frame already in flight when reset releases is never picked up halfway.
    assign fvalRise = iFVAL & ~fvalPrev & fvalArmed;
    assign fvalFall = ~iFVAL & fvalPrev;
    assign running  = (state == PRIME) || (state == ACTIVE);
    assign oLB_EN   = iDVAL & running;
    // The pixel that coincides with the frame-end edge is dropped.
    assign accept   = oLB_EN & ~fvalFall;
    assign shortEnd = running & fvalFall &
                      ((state == PRIME) || (oY_Cont < COORD_W'(IMG_H - 1)));

    // Coordinate of the pixel being accepted now; the registers hold the previous one.
    always_comb begin
        pixX = oX_Cont;
        pixY = oY_Cont;
        ovf  = 1'b0;
        if (!pixSeen) begin
            pixX = '0;
            pixY = '0;
        end else if (oX_Cont == COORD_W'(IMG_W - 1)) begin
            if (oY_Cont == COORD_W'(IMG_H - 1)) begin
                ovf = 1'b1;
            end else begin
                pixX = '0;
                pixY = oY_Cont + 1'b1;
            end
        end else begin
            pixX = oX_Cont + 1'b1;
        end
    end

    assign inBorder = accept && !ovf && (state == ACTIVE) &&
                      (pixX >= COORD_W'(BORDER)) && (pixX < COORD_W'(IMG_W - BORDER)) &&
                      (pixY >= COORD_W'(BORDER)) && (pixY < COORD_W'(IMG_H - BORDER));

    // Next-state decode; a frame can start from IDLE or straight out of DONE.
    always_comb begin
        nextState  = state;
        startFrame = 1'b0;
        case (state)
            IDLE: begin
                if (fvalRise) begin
                    nextState  = PRIME;
                    startFrame = 1'b1;
                end
            end
            PRIME: begin
                if (fvalFall) begin
                    nextState = DONE;
                end else if (accept && !ovf && (pixX == COORD_W'(IMG_W - 1)) &&
                             (pixY == COORD_W'(1))) begin
                    nextState = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fvalFall) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (fvalRise) begin
                    nextState  = PRIME;
                    startFrame = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Edge detect, coordinate counters, direction latch, sticky error and registered status.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalPrev    <= 1'b0;
            fvalArmed   <= 1'b0;
            pixSeen     <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oIsHorz     <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            inBorderQ   <= 1'b0;
        end else begin
            fvalPrev    <= iFVAL;
            oBUSY       <= (nextState == PRIME) || (nextState == ACTIVE);
            oFRAME_DONE <= (nextState == DONE);
            inBorderQ   <= inBorder;
            if (!iFVAL) begin
                fvalArmed <= 1'b1;
            end
            if (startFrame) begin
                pixSeen    <= 1'b0;
                oX_Cont    <= '0;
                oY_Cont    <= '0;
                oIsHorz    <= iSW;
                oFRAME_ERR <= 1'b0;
            end else begin
                if (accept) begin
                    pixSeen <= 1'b1;
                    oX_Cont <= pixX;
                    oY_Cont <= pixY;
                    if (ovf) begin
                        oFRAME_ERR <= 1'b1;
                    end
                end
                if (shortEnd) begin
                    oFRAME_ERR <= 1'b1;
                end
            end
        end
    end

    conv_valid_dly #(
        .DEPTH (PIPE_LAT)
    ) u_win_dly (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (inBorderQ),
        .oQ   (oWIN_VALID)
    );

`ifdef CONV_CTRL_STATS_EN
    // Count frames that finished cleanly; wraps naturally at 16 bits.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oFRAME_CNT <= '0;
        end else if (oFRAME_DONE && !oFRAME_ERR) begin
            oFRAME_CNT <= oFRAME_CNT + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl on a reduced 40x30 image with a 10-pixel border.
// Stimulus pushes each pixel's expected coordinate and window flag; a monitor checks them on acceptance.
// Frame-level status (done, error, busy, direction) is checked directly by the stimulus.
module tb_conv_frame_ctrl;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int B  = 10;
    localparam int PL = 2;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iFVAL = 1'b0;
    logic        iDVAL = 1'b0;
    logic        iSW = 1'b0;
    logic [10:0] oX_Cont, oY_Cont;
    logic        oLB_EN, oIsHorz, oWIN_VALID, oBUSY, oFRAME_DONE, oFRAME_ERR;
`ifdef CONV_CTRL_STATS_EN
    logic [15:0] oFRAME_CNT;
`endif

    typedef struct {
        int x;
        int y;
        bit win;
    } pix_t;

    typedef struct {
        int due;
        bit win;
    } pend_t;

    pix_t  expQ[$];
    pend_t pendQ[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    winHigh = 0;
    int    expCnt = 0;

    always #5 iCLK = ~iCLK;

    conv_frame_ctrl #(
        .IMG_W    (W),
        .IMG_H    (H),
        .BORDER   (B),
        .PIPE_LAT (PL)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .iSW         (iSW),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oLB_EN      (oLB_EN),
        .oIsHorz     (oIsHorz),
        .oWIN_VALID  (oWIN_VALID),
        .oBUSY       (oBUSY),
        .oFRAME_DONE (oFRAME_DONE),
        .oFRAME_ERR  (oFRAME_ERR)
`ifdef CONV_CTRL_STATS_EN
        ,
        .oFRAME_CNT  (oFRAME_CNT)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on every accepted pixel check its coordinate, and check oWIN_VALID every cycle.
    always begin : monitor
        bit    lb;
        bit    expWin;
        pix_t  e;
        pend_t p;
        @(posedge iCLK);
        cyc++;
        lb = oLB_EN;
        #1;
        if (!iRST) begin
            expQ.delete();
            pendQ.delete();
        end else if (lb) begin
            chk("pixel_expected", int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("x_cont", int'(oX_Cont), e.x);
                chk("y_cont", int'(oY_Cont), e.y);
                p.due = cyc + PL;
                p.win = e.win;
                pendQ.push_back(p);
            end
        end
        expWin = 1'b0;
        if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
            p = pendQ.pop_front();
            expWin = p.win;
        end
        chk("win_valid", int'(oWIN_VALID), int'(expWin));
        if (oWIN_VALID) winHigh++;
    end

    // Stream n full lines starting at row y0; rows past the last one are overflow pixels.
    task automatic sendLines(input int y0, input int n);
        for (int y = y0; y < y0 + n; y++) begin
            for (int x = 0; x < W; x++) begin
                pix_t e;
                if (y >= H) begin
                    e.x = W - 1;
                    e.y = H - 1;
                    e.win = 1'b0;
                end else begin
                    e.x = x;
                    e.y = y;
                    e.win = (x >= B) && (x < W - B) && (y >= B) && (y < H - B);
                end
                expQ.push_back(e);
                iDVAL = 1'b1;
                @(negedge iCLK);
            end
        end
        iDVAL = 1'b0;
    endtask

    task automatic startFrame(input bit sw);
        iFVAL = 1'b1;
        iSW = sw;
        winHigh = 0;
        @(negedge iCLK);
        chk("start_busy", int'(oBUSY), 1);
        chk("start_is_horz", int'(oIsHorz), int'(sw));
        chk("start_err_clear", int'(oFRAME_ERR), 0);
        chk("start_x", int'(oX_Cont), 0);
        chk("start_y", int'(oY_Cont), 0);
    endtask

    // Drop iFVAL and check the DONE cycle; leaves the bench at the DONE-cycle negedge.
    task automatic endFrame(input bit expErr);
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        @(negedge iCLK);
        chk("done_pulse", int'(oFRAME_DONE), 1);
        chk("done_busy", int'(oBUSY), 0);
        chk("done_err", int'(oFRAME_ERR), int'(expErr));
        if (!expErr) expCnt++;
    endtask

    task automatic afterDone();
        @(negedge iCLK);
        chk("done_one_cycle", int'(oFRAME_DONE), 0);
`ifdef CONV_CTRL_STATS_EN
        chk("frame_cnt", int'(oFRAME_CNT), expCnt);
`endif
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        // Reset state
        repeat (3) @(negedge iCLK);
        chk("rst_x", int'(oX_Cont), 0);
        chk("rst_y", int'(oY_Cont), 0);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_done", int'(oFRAME_DONE), 0);
        chk("rst_err", int'(oFRAME_ERR), 0);
        chk("rst_horz", int'(oIsHorz), 0);
        chk("rst_lb_en", int'(oLB_EN), 0);
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);

        // iDVAL while IDLE is ignored
        iDVAL = 1'b1;
        repeat (3) @(negedge iCLK);
        chk("idle_lb_en", int'(oLB_EN), 0);
        iDVAL = 1'b0;
        @(negedge iCLK);
        chk("idle_x", int'(oX_Cont), 0);
        chk("idle_err", int'(oFRAME_ERR), 0);
        chk("idle_busy", int'(oBUSY), 0);

        // Frame A: nominal, iSW=1 at start and flipped to 0 mid-frame
        startFrame(1'b1);
        sendLines(0, 15);
        iSW = 1'b0;
        sendLines(15, 15);
        chk("mid_frame_horz", int'(oIsHorz), 1);
        endFrame(1'b0);
        afterDone();
        chk("a_win_count", winHigh, (W - 2 * B) * (H - 2 * B));
        chk("a_horz_held", int'(oIsHorz), 1);

        // Frame B: short (10 lines), iSW=0 latched; frame C starts back-to-back out of DONE
        startFrame(1'b0);
        sendLines(0, 10);
        endFrame(1'b1);
        iFVAL = 1'b1;
        iSW = 1'b1;
        winHigh = 0;
        @(negedge iCLK);
        chk("b2b_done_low", int'(oFRAME_DONE), 0);
        chk("b2b_busy", int'(oBUSY), 1);
        chk("b2b_err_cleared", int'(oFRAME_ERR), 0);
        chk("b2b_horz", int'(oIsHorz), 1);
        chk("b2b_x", int'(oX_Cont), 0);

        // Frame C: overflow, 31 lines sent
        sendLines(0, H + 1);
        @(negedge iCLK);
        chk("ovf_err", int'(oFRAME_ERR), 1);
        chk("ovf_x_hold", int'(oX_Cont), W - 1);
        chk("ovf_y_hold", int'(oY_Cont), H - 1);
        chk("ovf_win_count", winHigh, (W - 2 * B) * (H - 2 * B));
        endFrame(1'b1);
        afterDone();

        // Frame D: reset mid-frame with iFVAL and iDVAL still high
        startFrame(1'b0);
        sendLines(0, 15);
        iDVAL = 1'b1;
        iRST = 1'b0;
        expCnt = 0;
        #1;
        chk("mrst_x", int'(oX_Cont), 0);
        chk("mrst_y", int'(oY_Cont), 0);
        chk("mrst_busy", int'(oBUSY), 0);
        chk("mrst_lb_en", int'(oLB_EN), 0);
        chk("mrst_win", int'(oWIN_VALID), 0);
        chk("mrst_err", int'(oFRAME_ERR), 0);
        chk("mrst_done", int'(oFRAME_DONE), 0);
`ifdef CONV_CTRL_STATS_EN
        chk("mrst_frame_cnt", int'(oFRAME_CNT), 0);
`endif
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        repeat (5) @(negedge iCLK);
        chk("no_start_busy", int'(oBUSY), 0);
        chk("no_start_lb_en", int'(oLB_EN), 0);
        chk("no_start_x", int'(oX_Cont), 0);
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        @(negedge iCLK);

        // Frame E: fresh edge starts a frame; ending in PRIME flags an error
        startFrame(1'b1);
        endFrame(1'b1);
        afterDone();
        chk("e_busy_idle", int'(oBUSY), 0);

        repeat (4) @(negedge iCLK);
        chk("scoreboard_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
